// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: state encoding, BCD digit type, wrap default.
package stopwatch_pkg;

    localparam int DIGIT_W          = 4;
    localparam int MIN_WRAP_DEFAULT = 60;
    localparam int BTN_SS           = 0;
    localparam int BTN_CLR          = 1;
    localparam int NUM_BTN          = 2;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    function automatic bcd_t bcd_tens(input int v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t bcd_ones(input int v);
        return bcd_t'(v % 10);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one pushbutton.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       r_press;

    // The detector only arms once the synchronizer holds real samples and has
    // seen the button low, so a button held through reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_fill != 2'd2)
                r_fill <= r_fill + 2'd1;
            if (r_fill == 2'd2 && !r_sync2)
                r_armed <= 1'b1;
            r_press <= r_armed & r_sync2 & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control FSM (IDLE/RUN/PAUSE) and MM:SS BCD counter driven by a one-second tick.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_WRAP = MIN_WRAP_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic cnt_en,
    output logic cnt_clr,
    output bcd_t sec_ones,
    output bcd_t sec_tens,
    output bcd_t min_ones,
    output bcd_t min_tens,
    output logic running,
    output logic wrap
);

    localparam bcd_t MW_TENS = bcd_tens(MIN_WRAP - 1);
    localparam bcd_t MW_ONES = bcd_ones(MIN_WRAP - 1);

    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_press;
    logic               w_ss_press;
    logic               w_clr_press;

    assign w_btn[BTN_SS]  = btn_ss;
    assign w_btn[BTN_CLR] = btn_clr;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge u_btn_edge (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (w_btn[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    assign w_ss_press  = w_press[BTN_SS];
    assign w_clr_press = w_press[BTN_CLR];

    sw_state_e r_state;
    sw_state_e w_state_next;
    logic      w_cnt_clr_next;
    logic      r_cnt_en;
    logic      r_cnt_clr;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_clr_next = 1'b0;
        if (w_clr_press) begin
            w_state_next   = ST_IDLE;
            w_cnt_clr_next = 1'b1;
        end else if (w_ss_press) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next   = ST_RUN;
                    w_cnt_clr_next = 1'b1;
                end
                ST_RUN:   w_state_next = ST_PAUSE;
                ST_PAUSE: w_state_next = ST_RUN;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt_en  <= (w_state_next == ST_RUN);
            r_cnt_clr <= w_cnt_clr_next;
        end
    end

    bcd_t r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic r_wrap;
    logic w_count;
    logic w_min_last;

    // The tick is judged against the current state, so a tick landing on the
    // RUN->PAUSE edge still counts while one on IDLE->RUN does not.
    assign w_count    = tick && (r_state == ST_RUN) && !w_clr_press;
    assign w_min_last = (r_min_tens == MW_TENS) && (r_min_ones == MW_ONES);

    always_ff @(posedge clk) begin
        if (rst || w_clr_press) begin
            r_sec_ones <= '0;
            r_sec_tens <= '0;
            r_min_ones <= '0;
            r_min_tens <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_count) begin
                if (r_sec_ones != bcd_t'(9)) begin
                    r_sec_ones <= r_sec_ones + bcd_t'(1);
                end else begin
                    r_sec_ones <= '0;
                    if (r_sec_tens != bcd_t'(5)) begin
                        r_sec_tens <= r_sec_tens + bcd_t'(1);
                    end else begin
                        r_sec_tens <= '0;
                        if (w_min_last) begin
                            r_min_ones <= '0;
                            r_min_tens <= '0;
                            r_wrap     <= 1'b1;
                        end else if (r_min_ones != bcd_t'(9)) begin
                            r_min_ones <= r_min_ones + bcd_t'(1);
                        end else begin
                            r_min_ones <= '0;
                            r_min_tens <= r_min_tens + bcd_t'(1);
                        end
                    end
                end
            end
        end
    end

    assign cnt_en   = r_cnt_en;
    assign cnt_clr  = r_cnt_clr;
    assign running  = (r_state == ST_RUN);
    assign wrap     = r_wrap;
    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: one instance at MIN_WRAP=60, one at MIN_WRAP=1.
module tb_stopwatch_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, tick_a = 1'b0, ss_a = 1'b0, clr_a = 1'b0;
    logic rst_b = 1'b1, tick_b = 1'b0, ss_b = 1'b0, clr_b = 1'b0;

    logic       en_a, cc_a, run_a, wr_a;
    logic [3:0] so_a, st_a, mo_a, mt_a;
    logic       en_b, cc_b, run_b, wr_b;
    logic [3:0] so_b, st_b, mo_b, mt_b;

    stopwatch_core #(.MIN_WRAP(60)) dut_a (
        .clk(clk), .rst(rst_a), .tick(tick_a), .btn_ss(ss_a), .btn_clr(clr_a),
        .cnt_en(en_a), .cnt_clr(cc_a),
        .sec_ones(so_a), .sec_tens(st_a), .min_ones(mo_a), .min_tens(mt_a),
        .running(run_a), .wrap(wr_a)
    );

    stopwatch_core #(.MIN_WRAP(1)) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick_b), .btn_ss(ss_b), .btn_clr(clr_b),
        .cnt_en(en_b), .cnt_clr(cc_b),
        .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .min_tens(mt_b),
        .running(run_b), .wrap(wr_b)
    );

    // digits as MM:SS hex-BCD, flags ordered {cnt_en, cnt_clr, running, wrap}
    wire [15:0] dig_a = {mt_a, mo_a, st_a, so_a};
    wire [15:0] dig_b = {mt_b, mo_b, st_b, so_b};
    wire [3:0]  fl_a  = {en_a, cc_a, run_a, wr_a};
    wire [3:0]  fl_b  = {en_b, cc_b, run_b, wr_b};

    typedef struct {
        int          at;
        bit          dut_b;
        string       nm;
        logic [15:0] dig;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    bit   range_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares queued expectations in the cycle they fall due.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                logic [15:0] gd;
                logic [3:0]  gf;
                gd = sb[i].dut_b ? dig_b : dig_a;
                gf = sb[i].dut_b ? fl_b : fl_a;
                n_cmp++;
                if (gd !== sb[i].dig || gf !== sb[i].fl) begin
                    n_err++;
                    $display("FAIL %s dut=%s cyc=%0d: got dig=%h flags=%b, want dig=%h flags=%b",
                             sb[i].nm, sb[i].dut_b ? "B" : "A", cyc, gd, gf, sb[i].dig, sb[i].fl);
                end else begin
                    $display("ok   %s dut=%s cyc=%0d dig=%h flags=%b",
                             sb[i].nm, sb[i].dut_b ? "B" : "A", cyc, gd, gf);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: expectation for cyc %0d never checked", sb[i].nm, sb[i].at);
                sb.delete(i);
            end
        end
        if (range_on) begin
            n_cmp += 2;
            if (so_a > 4'd9 || st_a > 4'd9 || mo_a > 4'd9 || mt_a > 4'd9) begin
                n_err++;
                $display("FAIL digit_range dut=A cyc=%0d: got %h, want every digit <= 9", cyc, dig_a);
            end
            if (so_b > 4'd9 || st_b > 4'd9 || mo_b > 4'd9 || mt_b > 4'd9) begin
                n_err++;
                $display("FAIL digit_range dut=B cyc=%0d: got %h, want every digit <= 9", cyc, dig_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input bit b, input int at, input string nm,
                             input logic [15:0] dig, input logic [3:0] fl);
        exp_t e;
        e.at = at; e.dut_b = b; e.nm = nm; e.dig = dig; e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic set_in(input bit b, input bit ss, input bit clr, input bit tk);
        if (b) begin
            ss_b = ss; clr_b = clr; tick_b = tk;
        end else begin
            ss_a = ss; clr_a = clr; tick_a = tk;
        end
    endtask

    task automatic ticks(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(b, 1'b0, 1'b0, 1'b1);
            step();
            set_in(b, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    // One-cycle button press starting now; the press takes effect at edge now+4,
    // and with tk set a tick is presented on exactly that edge.
    task automatic press_tick(input bit b, input bit ss, input bit clr, input bit tk);
        set_in(b, ss, clr, 1'b0);
        step();
        set_in(b, 1'b0, 1'b0, 1'b0);
        step();
        step();
        set_in(b, 1'b0, 1'b0, tk);
        step();
        set_in(b, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        // reset both instances
        for (int d = 0; d < 2; d++) begin
            expect_at(d[0], 1, "reset_1", 16'h0000, 4'b0100);
            expect_at(d[0], 2, "reset_2", 16'h0000, 4'b0100);
            expect_at(d[0], 3, "reset_release", 16'h0000, 4'b0000);
        end
        step();
        range_on = 1'b1;
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) step();

        // start/stop held five cycles: one state change at +4, one cnt_clr pulse
        k = cyc;
        expect_at(0, k + 3, "ss_hold_still_idle", 16'h0000, 4'b0000);
        expect_at(0, k + 4, "ss_hold_run", 16'h0000, 4'b1110);
        for (int i = 5; i <= 9; i++)
            expect_at(0, k + i, "ss_hold_steady", 16'h0000, 4'b1010);
        ss_a = 1'b1;
        repeat (5) step();
        ss_a = 1'b0;
        repeat (5) step();

        // seconds carry and full minute wrap at MIN_WRAP=60
        ticks(0, 59);
        expect_at(0, cyc, "at_0059", 16'h0059, 4'b1010);
        ticks(0, 1);
        expect_at(0, cyc, "carry_0100", 16'h0100, 4'b1010);
        ticks(0, 3539);
        expect_at(0, cyc, "at_5959", 16'h5959, 4'b1010);
        k = cyc;
        expect_at(0, k + 1, "wrap_pulse", 16'h0000, 4'b1011);
        expect_at(0, k + 2, "wrap_drop", 16'h0000, 4'b1010);
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        step();

        // pause with a coincident tick, then ticks ignored, then resume without cnt_clr
        ticks(0, 6);
        k = cyc;
        expect_at(0, k + 3, "pre_pause", 16'h0006, 4'b1010);
        expect_at(0, k + 4, "pause_tick_counted", 16'h0007, 4'b0000);
        press_tick(0, 1'b1, 1'b0, 1'b1);
        ticks(0, 10);
        expect_at(0, cyc, "pause_ignores_ticks", 16'h0007, 4'b0000);
        k = cyc;
        expect_at(0, k + 3, "pause_hold", 16'h0007, 4'b0000);
        expect_at(0, k + 4, "resume_no_clr", 16'h0007, 4'b1010);
        expect_at(0, k + 5, "resume_steady", 16'h0007, 4'b1010);
        press_tick(0, 1'b1, 1'b0, 1'b0);
        step();

        // clear coincident with a tick at 12:34
        ticks(0, 747);
        expect_at(0, cyc, "at_1234", 16'h1234, 4'b1010);
        k = cyc;
        expect_at(0, k + 4, "clear_tick", 16'h0000, 4'b0100);
        expect_at(0, k + 5, "clear_done", 16'h0000, 4'b0000);
        press_tick(0, 1'b0, 1'b1, 1'b1);
        step();

        // simultaneous start/stop and clear from RUN -> clear wins
        k = cyc;
        expect_at(0, k + 4, "restart", 16'h0000, 4'b1110);
        press_tick(0, 1'b1, 1'b0, 1'b0);
        step();
        ticks(0, 3);
        expect_at(0, cyc, "at_0003", 16'h0003, 4'b1010);
        k = cyc;
        expect_at(0, k + 4, "ss_clr_same", 16'h0000, 4'b0100);
        expect_at(0, k + 5, "ss_clr_after", 16'h0000, 4'b0000);
        press_tick(0, 1'b1, 1'b1, 1'b0);
        repeat (2) step();

        // reset mid-RUN at 03:21 overriding tick and button; button held through release
        k = cyc;
        expect_at(0, k + 4, "run_again", 16'h0000, 4'b1110);
        press_tick(0, 1'b1, 1'b0, 1'b0);
        step();
        ticks(0, 201);
        expect_at(0, cyc, "at_0321", 16'h0321, 4'b1010);
        k = cyc;
        expect_at(0, k + 1, "rst_mid_run", 16'h0000, 4'b0100);
        expect_at(0, k + 2, "rst_released", 16'h0000, 4'b0000);
        expect_at(0, k + 9, "held_btn_no_press", 16'h0000, 4'b0000);
        rst_a = 1'b1; tick_a = 1'b1; ss_a = 1'b1;
        step();
        rst_a = 1'b0; tick_a = 1'b0;
        repeat (8) step();
        ss_a = 1'b0;
        repeat (4) step();
        k = cyc;
        expect_at(0, k + 4, "press_after_release", 16'h0000, 4'b1110);
        press_tick(0, 1'b1, 1'b0, 1'b0);
        step();

        // MIN_WRAP=1: 60 ticks from 00:00 wrap back to 00:00
        k = cyc;
        expect_at(1, k + 4, "b_run", 16'h0000, 4'b1110);
        press_tick(1, 1'b1, 1'b0, 1'b0);
        step();
        ticks(1, 59);
        expect_at(1, cyc, "b_at_0059", 16'h0059, 4'b1010);
        k = cyc;
        expect_at(1, k + 1, "b_wrap_pulse", 16'h0000, 4'b1011);
        expect_at(1, k + 2, "b_wrap_drop", 16'h0000, 4'b1010);
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        step();

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_err += sb.size();
            n_cmp += sb.size();
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
